// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: block refill/write-back bus between the data cache and the memory responder.
interface data_mem_responder_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;
  logic              protocol_err;
  modport master (
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait, protocol_err
  );
  modport slave (
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait, protocol_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency block memory serving one cache refill or write-back per request.
module data_mem_responder #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 5
) (
  input logic clock,
  input logic reset,
  data_mem_responder_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            state;
  logic [3:0]        cnt;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];
  // Combinational so the cache stalls in the very cycle it raises a request.
  assign bus.mem_busywait = (state == IDLE && (bus.mem_read ^ bus.mem_write)) || state == BUSY;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      op_write         <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      bus.mem_readdata <= '0;
      bus.protocol_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_read ^ bus.mem_write) begin
            op_write <= bus.mem_write;
            addr_q   <= bus.mem_address;
            wdata_q  <= bus.mem_writedata;
            cnt      <= 4'd1;
            state    <= BUSY;
          end else if (bus.mem_read && bus.mem_write) begin
            bus.protocol_err <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == 4'(LATENCY - 1)) begin
            if (op_write) mem[addr_q] <= wdata_q;
            else bus.mem_readdata <= mem[addr_q];
            state <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        // DONE ignores requests: the cache is still dropping the one just served.
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed scoreboard bench for data_mem_responder.
module tb_data_mem_responder;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb [$];
  data_mem_responder_if #(.ADDR_W(6), .DATA_W(32)) bus ();
  data_mem_responder #(.ADDR_W(6), .DATA_W(32), .LATENCY(5)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Drives a request just after a posedge (cycle 0), counts busywait cycles, returns at the DONE negedge.
  task automatic access(input string tag, input bit wr, input logic [5:0] a, input logic [31:0] d, input bit hold);
    int n = 0;
    @(posedge clock);
    #1;
    bus.mem_read      = ~wr;
    bus.mem_write     = wr;
    bus.mem_address   = a;
    bus.mem_writedata = d;
    if (!wr) sb.push_back(d);
    @(negedge clock);
    while (bus.mem_busywait && n < 20) begin
      n++;
      @(negedge clock);
    end
    chk({tag, "_busy_cycles"}, n, 5);
    if (!wr) chk({tag, "_rdata"}, bus.mem_readdata, sb.size() > 0 ? sb.pop_front() : 32'hxxxxxxxx);
    if (!hold) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
  endtask
  initial begin
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_address = '0;
    bus.mem_writedata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    chk("rst_busy", 32'(bus.mem_busywait), 0);
    chk("rst_rdata", bus.mem_readdata, 32'h0);
    chk("rst_perr", 32'(bus.protocol_err), 0);
    access("rd2a", 1'b0, 6'h2A, 32'h0, 1'b0);
    access("wr05", 1'b1, 6'h05, 32'hDEADBEEF, 1'b0);
    access("rd05", 1'b0, 6'h05, 32'hDEADBEEF, 1'b0);
    access("pre07", 1'b1, 6'h07, 32'hA5A5A5A5, 1'b0);
    access("wb1f", 1'b1, 6'h1F, 32'h11223344, 1'b0);
    chk("wb_rdata_hold", bus.mem_readdata, 32'hDEADBEEF);
    access("refill07", 1'b0, 6'h07, 32'hA5A5A5A5, 1'b0);
    access("rd1f", 1'b0, 6'h1F, 32'h11223344, 1'b0);
    access("hold_rd05", 1'b0, 6'h05, 32'hDEADBEEF, 1'b1);
    @(negedge clock);
    chk("hold_idle_busy", 32'(bus.mem_busywait), 1);
    bus.mem_read = 1'b0;
    @(negedge clock);
    chk("hold_no_reaccept", 32'(bus.mem_busywait), 0);
    @(posedge clock);
    #1;
    bus.mem_write = 1'b1;
    bus.mem_address = 6'h10;
    bus.mem_writedata = 32'hCAFEF00D;
    repeat (3) @(posedge clock);
    #1;
    bus.mem_write = 1'b0;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.mem_busywait), 0);
    chk("abort_rdata", bus.mem_readdata, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    access("rd10", 1'b0, 6'h10, 32'h0, 1'b0);
    access("rd05_clr", 1'b0, 6'h05, 32'h0, 1'b0);
    @(posedge clock);
    #1;
    bus.mem_read = 1'b1;
    bus.mem_write = 1'b1;
    bus.mem_address = 6'h07;
    repeat (3) begin
      @(negedge clock);
      chk("both_busy", 32'(bus.mem_busywait), 0);
    end
    chk("both_perr", 32'(bus.protocol_err), 1);
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    repeat (2) @(negedge clock);
    chk("perr_sticky", 32'(bus.protocol_err), 1);
    chk("both_no_access", bus.mem_readdata, 32'h0);
    access("rd07_after_err", 1'b0, 6'h07, 32'h0, 1'b0);
    chk("perr_sticky2", 32'(bus.protocol_err), 1);
    reset = 1'b0;
    #1;
    chk("perr_cleared", 32'(bus.protocol_err), 0);
    reset = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
